mips32_multicycle: RTL and testbench
====================================

Name: mips32_multicycle

Overview:
Parametrised multi-cycle successor to the single-cycle mips32 top. It executes the same MIPS subset through a control FSM instead of a single-cycle path. Instruction and data memories sit outside the block behind req/ack handshakes, so variable-latency memories can be attached. The PC is word-addressed and the PC width is configurable; it sits at the top of the processor hierarchy.

Parameters:
PC_WIDTH, 14, width of the word-addressed program counter and instruction address.
DADDR_WIDTH, 18, data-memory address width; taken from alu_result[DADDR_WIDTH-1:0].
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising-edge active.
rst  in  1  synchronous, active-high reset.
imem_req  out  1  instruction fetch request.
imem_addr  out  PC_WIDTH  fetch address (equals pc).
imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
imem_rdata  in  32  instruction word.
dmem_req  out  1  data access request.
dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
dmem_addr  out  DADDR_WIDTH  data address.
dmem_wdata  out  32  store data (rt value).
dmem_ack  in  1  access complete; dmem_rdata valid this cycle for loads.
dmem_rdata  in  32  load data.
halted  out  1  high while in HALT.
illegal  out  1  one-cycle pulse on an unsupported opcode or funct.
pc_out  out  PC_WIDTH  architectural PC (debug).

Behaviour:
- Reset (clk=1 edge with rst=1):
  - pc=RESET_PC, state=FETCH.
  - All req/we/halted/illegal outputs are 0; instruction register = 0.
  - Register file is cleared to 0.
  - rst dominates every other event.
- Reset mid-access: req drops on the next cycle. An ack arriving in or after the reset cycle is ignored. No register or PC update occurs.
- States and transitions:
  - FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack is sampled high. On ack: latch IR, go to DECODE. ack may arrive in the first cycle of req, giving minimum FETCH length 1 cycle.
  - DECODE: read rs/rt into A/B registers; compute branch target pc+1+sext(imm) (truncated to PC_WIDTH). Go to EXECUTE, or to HALT if IR==32'hFFFF_FFFF.
  - EXECUTE: ALU operation. Branches and jumps resolve here and return to FETCH. lw/sw go to MEM; all others go to WRITEBACK.
  - MEM: dmem_req=1, address and data held until dmem_ack. lw goes to WRITEBACK; sw returns to FETCH with pc+1.
  - WRITEBACK: write the destination register, pc<=pc+1, go to FETCH.
  - HALT: absorbing; only rst exits.
- Instruction cycle counts (zero-wait memories):
  - R-type / ori / lui: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq / bne / j / jal / jr: 3 cycles.
- Instructions and arithmetic (32-bit, wrap-around, no overflow trap):
  - R-type funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed compare, result 1/0), jr 0x08.
  - I-type: lw 0x23, sw 0x2B, beq 0x04, bne 0x05, ori 0x0D (zero-extended imm), lui 0x0F (imm<<16).
  - J-type: j 0x02, jal 0x03.
- Jumps and branches:
  - j / jal target = addr26[PC_WIDTH-1:0].
  - jal writes pc+1, zero-extended, to $31.
  - jr sets pc=rs[PC_WIDTH-1:0].
  - Taken branch: pc=target; not taken: pc+1.
- Register $0 reads as 0; writes to it are discarded.
- PC wraps modulo 2^PC_WIDTH.
- Unsupported opcode/funct: illegal pulses for one cycle in EXECUTE; the instruction is treated as a NOP (pc+1, no write).

Decomposition:
- Package mips32_pkg holds:
  - opcode and funct localparams;
  - state encoding (FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT);
  - ALU-op encoding;
  - HALT_WORD constant.
- One natural sub-module: mips32_regfile. It has 2 asynchronous read ports and 1 synchronous write port, synchronous clear on rst, and $0 hardwired to zero.

Test Plan:
- Zero-wait: ori $1,$0,5; ori $2,$0,7; add $3,$1,$2; halt -> $3=12; halted=1 after exactly 4+4+4+2 cycles; pc_out=3.
- imem_ack delayed 3 cycles per fetch -> imem_addr stable while req is high; same final register values; each instruction takes 3 extra cycles.
- sw $3,4($0) then lw $4,4($0) with dmem_ack delayed 2 cycles -> store issued with dmem_addr=4, dmem_wdata=12, dmem_we=1; $4=12.
- At pc=10: beq $1,$1,-3 -> pc=8. bne $1,$1,5 -> pc=11.
- jal 20 at pc=6 -> $31=7, pc=20; then jr $31 -> pc=7. Separately, ori $0,$0,9 -> $0 still reads 0.
- rst asserted while FETCH waits on ack (ack arrives the same cycle) -> pc=0, regs=0, no IR latch. Opcode 0x3E -> illegal high 1 cycle, pc+1. lui $5,0x8000; slt $6,$5,$0 -> $6=1.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared encodings for the multi-cycle MIPS32 subset: opcodes, functs, FSM states, ALU ops.
package mips32_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        MEM,
        WRITEBACK,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_LUI
    } alu_op_t;

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] res;
        res = '0;
        case (op)
            ALU_ADD: res = a + b;
            ALU_SUB: res = a - b;
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_LUI: res = {b[15:0], 16'h0000};
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mips32_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, $0 fixed at zero.
module mips32_regfile
    import mips32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];

endmodule

// File: rtl/mips32_multicycle.sv
// Multi-cycle MIPS32 subset core; instruction and data memories attach through req/ack handshakes.
module mips32_multicycle
    import mips32_pkg::*;
#(
    parameter int PC_WIDTH    = 14,
    parameter int DADDR_WIDTH = 18,
    parameter int RESET_PC    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DADDR_WIDTH-1:0] dmem_addr,
    output logic [31:0]            dmem_wdata,
    input  logic                   dmem_ack,
    input  logic [31:0]            dmem_rdata,
    output logic                   halted,
    output logic                   illegal,
    output logic [PC_WIDTH-1:0]    pc_out
);

    state_t state, state_next;

    logic [PC_WIDTH-1:0] pc, pc_plus1, target;
    logic [31:0]         ir, a_reg, b_reg, alu_out, mdr;
    // Low for the first cycle after reset so a stale ack from an aborted fetch is never taken.
    logic                req_en;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext_imm, zext_imm, op_b, alu_res;
    logic [31:0] rd1, rd2;
    logic        is_alu_r, is_jr, is_j, is_jal, is_beq, is_bne;
    logic        is_lw, is_sw, is_ori, is_lui, is_illegal, taken;
    alu_op_t     alu_op;

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    assign opcode   = ir[31:26];
    assign rs       = ir[25:21];
    assign rt       = ir[20:16];
    assign rd       = ir[15:11];
    assign funct    = ir[5:0];
    assign sext_imm = {{16{ir[15]}}, ir[15:0]};
    assign zext_imm = {16'h0000, ir[15:0]};
    assign pc_plus1 = pc + PC_WIDTH'(1);

    always_comb begin
        is_alu_r   = 1'b0;
        is_jr      = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_lw      = 1'b0;
        is_sw      = 1'b0;
        is_ori     = 1'b0;
        is_lui     = 1'b0;
        is_illegal = 1'b0;
        alu_op     = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  begin is_alu_r = 1'b1; alu_op = ALU_ADD; end
                    FN_SUB:  begin is_alu_r = 1'b1; alu_op = ALU_SUB; end
                    FN_AND:  begin is_alu_r = 1'b1; alu_op = ALU_AND; end
                    FN_OR:   begin is_alu_r = 1'b1; alu_op = ALU_OR;  end
                    FN_SLT:  begin is_alu_r = 1'b1; alu_op = ALU_SLT; end
                    FN_JR:   is_jr = 1'b1;
                    default: is_illegal = 1'b1;
                endcase
            end
            OP_J:    is_j   = 1'b1;
            OP_JAL:  is_jal = 1'b1;
            OP_BEQ:  is_beq = 1'b1;
            OP_BNE:  is_bne = 1'b1;
            OP_LW:   is_lw  = 1'b1;
            OP_SW:   is_sw  = 1'b1;
            OP_ORI:  begin is_ori = 1'b1; alu_op = ALU_OR;  end
            OP_LUI:  begin is_lui = 1'b1; alu_op = ALU_LUI; end
            default: is_illegal = 1'b1;
        endcase
    end

    assign op_b    = is_alu_r ? b_reg : ((is_ori || is_lui) ? zext_imm : sext_imm);
    assign alu_res = alu(alu_op, a_reg, op_b);
    assign taken   = (is_beq && (a_reg == b_reg)) || (is_bne && (a_reg != b_reg));

    mips32_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .raddr2 (rt),
        .rdata1 (rd1),
        .rdata2 (rd2),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata)
    );

    // jal links in EXECUTE so it keeps its three-cycle length; everything else writes in WRITEBACK.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rt;
        rf_wdata = alu_out;
        if (state == EXECUTE && is_jal) begin
            rf_we    = 1'b1;
            rf_waddr = 5'd31;
            rf_wdata = 32'(pc_plus1);
        end else if (state == WRITEBACK) begin
            rf_we = 1'b1;
            if (is_alu_r) rf_waddr = rd;
            if (is_lw)    rf_wdata = mdr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:     if (req_en && imem_ack) state_next = DECODE;
            DECODE:    state_next = (ir == HALT_WORD) ? HALT : EXECUTE;
            EXECUTE: begin
                if (is_lw || is_sw)      state_next = MEM;
                else if (is_alu_r || is_ori || is_lui) state_next = WRITEBACK;
                else                     state_next = FETCH;
            end
            MEM:       if (dmem_ack) state_next = is_lw ? WRITEBACK : FETCH;
            WRITEBACK: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_req = (state == FETCH) && req_en;
        dmem_req = (state == MEM);
        dmem_we  = (state == MEM) && is_sw;
        halted   = (state == HALT);
        illegal  = (state == EXECUTE) && is_illegal;
    end

    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign dmem_addr  = alu_out[DADDR_WIDTH-1:0];
    assign dmem_wdata = b_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= PC_WIDTH'(RESET_PC);
            ir      <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            mdr     <= '0;
            target  <= '0;
            req_en  <= 1'b0;
        end else begin
            req_en <= 1'b1;
            case (state)
                FETCH: begin
                    if (req_en && imem_ack) ir <= imem_rdata;
                end
                DECODE: begin
                    a_reg  <= rd1;
                    b_reg  <= rd2;
                    target <= pc_plus1 + sext_imm[PC_WIDTH-1:0];
                end
                EXECUTE: begin
                    alu_out <= alu_res;
                    if (is_jr)               pc <= a_reg[PC_WIDTH-1:0];
                    else if (is_j || is_jal) pc <= ir[PC_WIDTH-1:0];
                    else if (is_beq || is_bne) pc <= taken ? target : pc_plus1;
                    else if (is_illegal)     pc <= pc_plus1;
                end
                MEM: begin
                    if (dmem_ack) begin
                        mdr <= dmem_rdata;
                        if (is_sw) pc <= pc_plus1;
                    end
                end
                WRITEBACK: pc <= pc_plus1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips32_multicycle.sv
// Directed bench: ISA-level reference model checks fetch addresses, data accesses, halt PC and final registers.
module tb_mips32_multicycle;

    localparam int PCW = 14;
    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        dmem_req, dmem_we, dmem_ack = 1'b0;
    logic [17:0] dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata = '0;
    logic        halted, illegal;
    logic [13:0] pc_out;

    mips32_multicycle dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .halted     (halted),
        .illegal    (illegal),
        .pc_out     (pc_out)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [17:0] addr;
        logic [31:0] data;
    } dacc_t;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] imem [64];
    logic [31:0] dmem [256];
    logic [31:0] mregs [32];
    logic [31:0] mdm [256];
    logic [13:0] model_pc;
    logic        m_halt;
    int          m_ill;
    dacc_t       dq [$];

    int          ill_seen;
    int          halt_cycles;
    logic        st_seen;
    logic [31:0] st_addr, st_data;
    logic        st_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] j_op(input logic [5:0] op, input int addr);
        return {op, 26'(addr)};
    endfunction

    task automatic clear_imem();
        for (int k = 0; k < 64; k++) imem[k] = HW;
    endtask

    task automatic mw(input int idx, input logic [31:0] v);
        if (idx != 0) mregs[idx] = v;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) mregs[k] = '0;
        for (int k = 0; k < 256; k++) mdm[k] = '0;
        model_pc = '0;
        m_halt = 1'b0;
        m_ill = 0;
        dq.delete();
    endtask

    // Architectural effect of one instruction, applied when its fetch completes.
    task automatic model_step(input logic [31:0] w);
        logic [5:0]  op, fn;
        logic [31:0] va, vb, si, addr;
        logic [13:0] npc;
        dacc_t       e;
        op = w[31:26];
        fn = w[5:0];
        va = mregs[w[25:21]];
        vb = mregs[w[20:16]];
        si = {{16{w[15]}}, w[15:0]};
        addr = va + si;
        npc = model_pc + 14'd1;
        if (w == HW) begin
            m_halt = 1'b1;
            return;
        end
        case (op)
            6'h00: case (fn)
                6'h20: mw(int'(w[15:11]), va + vb);
                6'h22: mw(int'(w[15:11]), va - vb);
                6'h24: mw(int'(w[15:11]), va & vb);
                6'h25: mw(int'(w[15:11]), va | vb);
                6'h2A: mw(int'(w[15:11]), ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0);
                6'h08: npc = va[13:0];
                default: m_ill++;
            endcase
            6'h23: begin
                e.we = 1'b0; e.addr = addr[17:0]; e.data = '0;
                dq.push_back(e);
                mw(int'(w[20:16]), mdm[addr[7:0]]);
            end
            6'h2B: begin
                e.we = 1'b1; e.addr = addr[17:0]; e.data = vb;
                dq.push_back(e);
                mdm[addr[7:0]] = vb;
            end
            6'h04: if (va == vb) npc = model_pc + 14'd1 + si[13:0];
            6'h05: if (va != vb) npc = model_pc + 14'd1 + si[13:0];
            6'h0D: mw(int'(w[20:16]), va | {16'h0000, w[15:0]});
            6'h0F: mw(int'(w[20:16]), {w[15:0], 16'h0000});
            6'h02: npc = w[13:0];
            6'h03: begin
                mw(31, {18'h0, model_pc + 14'd1});
                npc = w[13:0];
            end
            default: m_ill++;
        endcase
        model_pc = npc;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_pc", 32'(pc_out), 32'd0);
        rst = 1'b0;
    endtask

    // Runs the loaded program until halted; rst_pc >= 0 resets the core on the ack of that fetch.
    task automatic run(input int idel, input int ddel, input int rst_pc);
        int cyc, first_req, icnt, dcnt;
        logic done, rst_done;
        logic [31:0] rall;
        dacc_t e;
        for (int k = 0; k < 256; k++) dmem[k] = '0;
        apply_reset();
        model_reset();
        cyc = 0; first_req = -1; icnt = 0; dcnt = 0;
        done = 1'b0; rst_done = 1'b0;
        ill_seen = 0; halt_cycles = -1; st_seen = 1'b0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (rst) begin
                chk("midrst_imem_req", 32'(imem_req), 32'd0);
                chk("midrst_pc", 32'(pc_out), 32'd0);
                chk("midrst_ir", dut.ir, 32'd0);
                rall = '0;
                for (int k = 0; k < 32; k++) rall = rall | dut.u_regfile.regs[k];
                chk("midrst_regs", rall, 32'd0);
                rst = 1'b0;
                model_reset();
                first_req = -1;
                icnt = 0;
                dcnt = 0;
            end else if (halted) begin
                done = 1'b1;
                halt_cycles = cyc - first_req;
                chk("halted", 32'(halted), 32'(m_halt));
                chk("halt_pc", 32'(pc_out), 32'(model_pc));
            end else begin
                if (illegal) ill_seen++;
                if (imem_req) begin
                    if (first_req < 0) first_req = cyc;
                    chk("imem_addr", 32'(imem_addr), 32'(model_pc));
                    if (icnt == idel) begin
                        imem_ack = 1'b1;
                        imem_rdata = imem[imem_addr[5:0]];
                        icnt = 0;
                        if (!rst_done && rst_pc >= 0 && int'(imem_addr) == rst_pc) begin
                            rst = 1'b1;
                            rst_done = 1'b1;
                        end else begin
                            model_step(imem[model_pc[5:0]]);
                        end
                    end else begin
                        icnt++;
                    end
                end else begin
                    icnt = 0;
                end
                if (dmem_req) begin
                    if (!st_seen) begin
                        st_seen = 1'b1;
                        st_we = dmem_we;
                        st_addr = 32'(dmem_addr);
                        st_data = dmem_wdata;
                    end
                    if (dq.size() == 0) begin
                        chk("dmem_unexpected", 32'(dmem_req), 32'd0);
                    end else begin
                        e = dq[0];
                        chk("dmem_we", 32'(dmem_we), 32'(e.we));
                        chk("dmem_addr", 32'(dmem_addr), 32'(e.addr));
                        if (e.we) chk("dmem_wdata", dmem_wdata, e.data);
                    end
                    if (dcnt == ddel) begin
                        dmem_ack = 1'b1;
                        if (dmem_we) dmem[dmem_addr[7:0]] = dmem_wdata;
                        else dmem_rdata = dmem[dmem_addr[7:0]];
                        if (dq.size() > 0) void'(dq.pop_front());
                        dcnt = 0;
                    end else begin
                        dcnt++;
                    end
                end else begin
                    dcnt = 0;
                end
            end
        end
        if (!done) chk("halt_timeout", 32'd0, 32'd1);
        for (int k = 0; k < 32; k++) chk($sformatf("reg%0d", k), dut.u_regfile.regs[k], mregs[k]);
        chk("illegal_pulses", 32'(ill_seen), 32'(m_ill));
        chk("dmem_pending", 32'(dq.size()), 32'd0);
    endtask

    task automatic load_p1();
        clear_imem();
        imem[0] = i_op(6'h0D, 1, 0, 16'd5);
        imem[1] = i_op(6'h0D, 2, 0, 16'd7);
        imem[2] = r_op(6'h20, 3, 1, 2);
        imem[3] = HW;
    endtask

    initial begin
        load_p1();
        run(0, 0, -1);
        chk("p1_cycles", 32'(halt_cycles), 32'd14);
        chk("p1_r3", dut.u_regfile.regs[3], 32'd12);
        chk("p1_pc", 32'(pc_out), 32'd3);

        run(3, 0, -1);
        chk("p2_cycles", 32'(halt_cycles), 32'd26);
        chk("p2_r3", dut.u_regfile.regs[3], 32'd12);

        run(3, 0, 1);
        chk("p5_cycles", 32'(halt_cycles), 32'd26);
        chk("p5_r3", dut.u_regfile.regs[3], 32'd12);

        clear_imem();
        imem[0]  = i_op(6'h0D, 1, 0, 16'd5);
        imem[1]  = i_op(6'h0D, 2, 0, 16'd7);
        imem[2]  = r_op(6'h20, 3, 1, 2);
        imem[3]  = i_op(6'h2B, 3, 0, 16'd4);
        imem[4]  = i_op(6'h23, 4, 0, 16'd4);
        imem[5]  = j_op(6'h02, 10);
        imem[10] = i_op(6'h04, 1, 1, 16'hFFFD);
        imem[8]  = j_op(6'h02, 6);
        imem[6]  = j_op(6'h03, 20);
        imem[20] = r_op(6'h08, 0, 31, 0);
        imem[7]  = j_op(6'h02, 13);
        imem[13] = i_op(6'h0D, 0, 0, 16'd9);
        imem[14] = {6'h3E, 26'h0};
        imem[15] = i_op(6'h0F, 5, 0, 16'h8000);
        imem[16] = r_op(6'h2A, 6, 5, 0);
        imem[17] = j_op(6'h02, 21);
        imem[21] = r_op(6'h22, 7, 2, 1);
        imem[22] = r_op(6'h24, 8, 1, 2);
        imem[23] = r_op(6'h25, 9, 1, 2);
        imem[24] = r_op(6'h2A, 10, 1, 2);
        imem[25] = i_op(6'h05, 2, 1, 16'd2);
        imem[28] = r_op(6'h20, 11, 3, 4);
        run(0, 2, -1);
        chk("p3_st_we", 32'(st_we), 32'd1);
        chk("p3_st_addr", st_addr, 32'd4);
        chk("p3_st_data", st_data, 32'd12);
        chk("p3_r4", dut.u_regfile.regs[4], 32'd12);
        chk("p3_r31", dut.u_regfile.regs[31], 32'd7);
        chk("p3_r0", dut.u_regfile.regs[0], 32'd0);
        chk("p3_r6", dut.u_regfile.regs[6], 32'd1);
        chk("p3_r7", dut.u_regfile.regs[7], 32'd2);
        chk("p3_r11", dut.u_regfile.regs[11], 32'd24);
        chk("p3_ill", 32'(ill_seen), 32'd1);
        chk("p3_pc", 32'(pc_out), 32'd29);

        clear_imem();
        imem[0]  = j_op(6'h02, 10);
        imem[10] = i_op(6'h05, 1, 1, 16'd5);
        run(0, 0, -1);
        chk("p4_pc", 32'(pc_out), 32'd11);
        chk("p4_cycles", 32'(halt_cycles), 32'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
